turn_manager: RTL
=================

Name: turn_manager

Overview:
- Top-level turn sequencer. It alternates play between the cat and dog players and drives the `cat_turn` input of `turn_remote_fsm` and the equivalent dog-side FSM.
- It consumes their `turn_done` pulses, inserts a fixed pause between turns, and enforces a per-turn timeout.
- At the start of each turn it samples a pseudo-random signed wind value for the projectile stage.
- It freezes play when the hit-point logic reports game over.

Parameters:
- TURN_GAP_CYCLES, 65000000, pause between turns (1 s at 65 MHz).
- TURN_TIMEOUT_CYCLES, 650000000, maximum turn length before a forced turn change (10 s).
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock (65 MHz)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle game-start/restart pulse
- cat_turn_done  in  1  single-cycle end-of-turn pulse from cat FSM
- dog_turn_done  in  1  single-cycle end-of-turn pulse from dog FSM
- game_over  in  1  level from HP logic; high when either player has 0 HP
- cat_turn  out  1  level, high during the cat's turn
- dog_turn  out  1  level, high during the dog's turn
- wind  out  4  signed wind, range -7..+7
- turn_count  out  8  completed turns, saturating
- timeout  out  1  single-cycle pulse when a turn is forced to end
- game_end  out  1  level, high in the END state

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE; all outputs are 0; counter is 0; LFSR holds LFSR_SEED.
- Output timing:
  - All outputs are registered.
  - `cat_turn`/`dog_turn` change on the same edge as the state change.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle while out of reset.
  - On entry to CAT_TURN or DOG_TURN, `wind` is loaded from `lfsr[3:0]` as signed; the value -8 is clamped to -7.
  - `wind` holds otherwise.
- States and transitions:
  - IDLE: on `start`, go to CAT_TURN, clear `turn_count`, counter = 0.
  - CAT_TURN (`cat_turn`=1):
    - `cat_turn_done` goes to GAP_TO_DOG.
    - If counter reaches TURN_TIMEOUT_CYCLES-1 first, go to GAP_TO_DOG and pulse `timeout`.
    - Otherwise the counter increments.
    - `dog_turn_done` is ignored.
  - GAP_TO_DOG (both turn outputs 0): count to TURN_GAP_CYCLES-1, then go to DOG_TURN with counter = 0.
  - DOG_TURN and GAP_TO_CAT: mirror of the cat-side states, with the roles swapped.
  - END (`game_end`=1, both turn outputs 0):
    - Holds until `start`, which goes to CAT_TURN with `turn_count` cleared and `game_end` cleared.
- Counter and `turn_count`:
  - Counter is 32 bits and is cleared on every state change.
  - Every exit from CAT_TURN/DOG_TURN (done or timeout) increments `turn_count`, saturating at 255.
- Priorities:
  - `game_over` high in any non-IDLE state goes to END on the next edge. It beats a simultaneous done or timeout; `turn_count` is not incremented.
  - Done and timeout on the same cycle count as a normal done: no `timeout` pulse.
  - `start` outside IDLE/END is ignored.
  - `game_over` in IDLE is ignored.
- Gap length: done asserted at cycle t means the other player's turn output rises at t+1+TURN_GAP_CYCLES.
- Reset mid-turn: immediately drops both turn outputs. The downstream FSMs see their turn input fall and return to idle.

Decomposition:
- `game_pkg`: state enum (IDLE, CAT_TURN, GAP_TO_DOG, DOG_TURN, GAP_TO_CAT, END) and the 65 MHz ONE_SECOND constant.
- Sub-module `lfsr16` (clk, rst_n, seed parameter, 16-bit state output), reusable by other random effects.

Test Plan (TURN_GAP_CYCLES=4, TURN_TIMEOUT_CYCLES=20):
- Reset, then `start` pulse:
  - `cat_turn`=1 next cycle; `dog_turn`=0; `turn_count`=0.
  - `wind` is in -7..+7.
- `cat_turn_done` at cycle t:
  - `cat_turn`=0 at t+1.
  - `dog_turn`=1 at t+5.
  - `turn_count`=1.
  - `wind` is reloaded at t+5.
- No done during DOG_TURN:
  - After 20 cycles, `timeout` pulses for exactly 1 cycle.
  - `dog_turn` falls; `cat_turn` rises 4 cycles later; `turn_count`=2.
- `game_over` and `cat_turn_done` in the same cycle:
  - END, `game_end`=1, both turns 0, `turn_count` unchanged.
  - A later `start` gives `cat_turn`=1 and `turn_count`=0.
- `dog_turn_done` during CAT_TURN: no state change. Then `rst_n` low mid-turn: all outputs 0 immediately, without waiting for a clock edge.
- 300 alternating done pulses: `turn_count` saturates at 255. Seeded LFSR sequence never produces `wind`=-8.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the cat/dog game: turn-sequencer state codes,
// the 65 MHz one-second constant and the wind clamp helper.
package game_pkg;

    localparam int unsigned ONE_SECOND = 32'd65_000_000;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CAT_TURN   = 3'd1;
    localparam logic [2:0] ST_GAP_TO_DOG = 3'd2;
    localparam logic [2:0] ST_DOG_TURN   = 3'd3;
    localparam logic [2:0] ST_GAP_TO_CAT = 3'd4;
    localparam logic [2:0] ST_END        = 3'd5;

    // Raw two's-complement nibble to wind; -8 has no positive mirror so it becomes -7.
    function automatic logic [3:0] clamp_wind(input logic [3:0] raw);
        if (raw == 4'b1000) begin
            return 4'b1001;
        end else begin
            return raw;
        end
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reusable by any
// effect that needs cheap pseudo-random bits.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    logic feedback_s;

    assign feedback_s = state[15] ^ state[13] ^ state[12] ^ state[10];

    // Shift register advances every cycle; the seed must be non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], feedback_s};
        end
    end

endmodule

// File: rtl/turn_manager.sv
// Top-level turn sequencer: alternates cat and dog turns with a fixed gap,
// forces turn changes on timeout, samples wind per turn and freezes on game over.
module turn_manager
    import game_pkg::*;
#(
    parameter int unsigned TURN_GAP_CYCLES     = ONE_SECOND,
    parameter int unsigned TURN_TIMEOUT_CYCLES = 32'd650_000_000,
    parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cat_turn_done,
    input  logic       dog_turn_done,
    input  logic       game_over,
    output logic       cat_turn,
    output logic       dog_turn,
    output logic [3:0] wind,
    output logic [7:0] turn_count,
    output logic       timeout,
    output logic       game_end
);

    localparam logic [31:0] GAP_LAST     = 32'(TURN_GAP_CYCLES - 32'd1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TURN_TIMEOUT_CYCLES - 32'd1);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [31:0] cnt_r;
    logic        turn_exit_s;
    logic        timeout_s;
    logic        turn_entry_s;
    logic        restart_s;
    logic [15:0] lfsr_s;
    logic        lfsr_unused_s;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s[15:4];

    // Next-state selection; game_over outranks done, done outranks timeout.
    always_comb begin
        state_nxt_s = state_r;
        turn_exit_s = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CAT_TURN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAT_TURN: begin
                if (game_over) begin
                    state_nxt_s = ST_END;
                end else if (cat_turn_done) begin
                    state_nxt_s = ST_GAP_TO_DOG;
                    turn_exit_s = 1'b1;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s = ST_GAP_TO_DOG;
                    turn_exit_s = 1'b1;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_CAT_TURN;
                end
            end
            ST_GAP_TO_DOG: begin
                if (game_over) begin
                    state_nxt_s = ST_END;
                end else if (cnt_r == GAP_LAST) begin
                    state_nxt_s = ST_DOG_TURN;
                end else begin
                    state_nxt_s = ST_GAP_TO_DOG;
                end
            end
            ST_DOG_TURN: begin
                if (game_over) begin
                    state_nxt_s = ST_END;
                end else if (dog_turn_done) begin
                    state_nxt_s = ST_GAP_TO_CAT;
                    turn_exit_s = 1'b1;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s = ST_GAP_TO_CAT;
                    turn_exit_s = 1'b1;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_DOG_TURN;
                end
            end
            ST_GAP_TO_CAT: begin
                if (game_over) begin
                    state_nxt_s = ST_END;
                end else if (cnt_r == GAP_LAST) begin
                    state_nxt_s = ST_CAT_TURN;
                end else begin
                    state_nxt_s = ST_GAP_TO_CAT;
                end
            end
            ST_END: begin
                if (game_over) begin
                    state_nxt_s = ST_END;
                end else if (start) begin
                    state_nxt_s = ST_CAT_TURN;
                end else begin
                    state_nxt_s = ST_END;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign turn_entry_s = (state_nxt_s != state_r) &&
                          ((state_nxt_s == ST_CAT_TURN) || (state_nxt_s == ST_DOG_TURN));
    assign restart_s    = (state_nxt_s == ST_CAT_TURN) &&
                          ((state_r == ST_IDLE) || (state_r == ST_END));

    // State, cycle counter and the state-decoded outputs move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 32'd0;
            cat_turn <= 1'b0;
            dog_turn <= 1'b0;
            game_end <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= 32'd0;
            end else begin
                cnt_r <= cnt_r + 32'd1;
            end
            cat_turn <= (state_nxt_s == ST_CAT_TURN);
            dog_turn <= (state_nxt_s == ST_DOG_TURN);
            game_end <= (state_nxt_s == ST_END);
            timeout  <= timeout_s;
        end
    end

    // Wind sampled once per turn entry, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wind <= 4'd0;
        end else if (turn_entry_s) begin
            wind <= clamp_wind(lfsr_s[3:0]);
        end else begin
            wind <= wind;
        end
    end

    // Completed-turn counter: cleared on (re)start, saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_count <= 8'd0;
        end else if (restart_s) begin
            turn_count <= 8'd0;
        end else if (turn_exit_s && (turn_count != 8'hFF)) begin
            turn_count <= turn_count + 8'd1;
        end else begin
            turn_count <= turn_count;
        end
    end

endmodule
